// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation minimum-SAD tracker.
package me_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    // Caller narrows the result to its own width.
    function automatic logic [31:0] sad_all_ones(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [31:0] l1_dist(input logic [31:0] col, input logic [31:0] row,
                                            input logic [31:0] ccol, input logic [31:0] crow);
        logic [31:0] dc;
        logic [31:0] dr;
        dc = (col >= ccol) ? (col - ccol) : (ccol - col);
        dr = (row >= crow) ? (row - crow) : (crow - row);
        return dc + dr;
    endfunction

endpackage

// File: rtl/me_sad_compare.sv
// Combinational compare and tie-break: decides whether a candidate replaces
// the current best or only the second-best SAD.
module me_sad_compare
    import me_pkg::*;
#(
    parameter int SAD_W      = 14,
    parameter int COL_W      = 4,
    parameter int ROW_W      = 5,
    parameter int CENTER_COL = 8,
    parameter int CENTER_ROW = 8,
    parameter int TIE_MODE   = 0
) (
    input  logic [SAD_W-1:0] cand_sad_i,
    input  logic [COL_W-1:0] cand_col_i,
    input  logic [ROW_W-1:0] cand_row_i,
    input  logic [SAD_W-1:0] best_sad_i,
    input  logic [COL_W-1:0] best_col_i,
    input  logic [ROW_W-1:0] best_row_i,
    input  logic [SAD_W-1:0] second_sad_i,
    output logic             replace_best_o,
    output logic             replace_second_o
);

    localparam int DIST_W = ((COL_W > ROW_W) ? COL_W : ROW_W) + 1;

    logic [DIST_W-1:0] candDist;
    logic [DIST_W-1:0] bestDist;
    logic              tieWin;

    // Distances wrap at DIST_W bits, so both operands are narrowed identically.
    always_comb begin
        candDist = DIST_W'(l1_dist(32'(cand_col_i), 32'(cand_row_i),
                                   32'(CENTER_COL), 32'(CENTER_ROW)));
        bestDist = DIST_W'(l1_dist(32'(best_col_i), 32'(best_row_i),
                                   32'(CENTER_COL), 32'(CENTER_ROW)));
        tieWin           = (TIE_MODE == 1) && (cand_sad_i == best_sad_i) && (candDist < bestDist);
        replace_best_o   = (cand_sad_i < best_sad_i) || tieWin;
        replace_second_o = !replace_best_o && (cand_sad_i < second_sad_i);
    end

endmodule

// File: rtl/me_min_sad_tracker.sv
// Minimum-SAD tracker: keeps best and second-best SAD for one search block and
// hands the winning motion vector to the MV writer over a valid/ready handshake.
module me_min_sad_tracker
    import me_pkg::*;
#(
    parameter int SAD_W      = 14,
    parameter int COL_W      = 4,
    parameter int ROW_W      = 5,
    parameter int CENTER_COL = 8,
    parameter int CENTER_ROW = 8,
    parameter int TIE_MODE   = 0,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [COL_W-1:0] col_in,
    input  logic [ROW_W-1:0] row_in,
    input  logic             last_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SAD_W-1:0] best_sad,
    output logic [SAD_W-1:0] second_sad,
    output logic [COL_W-1:0] best_col,
    output logic [ROW_W-1:0] best_row,
    output logic [COL_W:0]   mv_x,
    output logic [ROW_W:0]   mv_y,
    output logic             found,
    output logic [CNT_W-1:0] cand_count
);

    localparam logic [SAD_W-1:0] SAD_ONES = SAD_W'(sad_all_ones(SAD_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state_q, state_d;

    logic [SAD_W-1:0] bestSad_q, bestSad_d;
    logic [SAD_W-1:0] secondSad_q, secondSad_d;
    logic [COL_W-1:0] bestCol_q, bestCol_d;
    logic [ROW_W-1:0] bestRow_q, bestRow_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] candCount_q, candCount_d;

    logic             accept;
    logic             clearAcc;
    logic [SAD_W-1:0] baseBest;
    logic [SAD_W-1:0] baseSecond;
    logic [COL_W-1:0] baseCol;
    logic [ROW_W-1:0] baseRow;
    logic             baseFound;
    logic [CNT_W-1:0] baseCount;
    logic             replaceBest;
    logic             replaceSecond;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (accept && last_in) ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                if (accept && last_in) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
    end

    // A start clears the accumulators, and a candidate in the same cycle is
    // judged against the cleared values so it opens the new block.
    always_comb begin
        accept     = in_valid && in_ready && ((state_q == SEARCH) || start);
        clearAcc   = start && (state_q != DONE);
        baseBest   = clearAcc ? SAD_ONES : bestSad_q;
        baseSecond = clearAcc ? SAD_ONES : secondSad_q;
        baseCol    = clearAcc ? '0 : bestCol_q;
        baseRow    = clearAcc ? '0 : bestRow_q;
        baseFound  = clearAcc ? 1'b0 : found_q;
        baseCount  = clearAcc ? '0 : candCount_q;
    end

    me_sad_compare #(
        .SAD_W      (SAD_W),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W),
        .CENTER_COL (CENTER_COL),
        .CENTER_ROW (CENTER_ROW),
        .TIE_MODE   (TIE_MODE)
    ) u_compare (
        .cand_sad_i       (sad_in),
        .cand_col_i       (col_in),
        .cand_row_i       (row_in),
        .best_sad_i       (baseBest),
        .best_col_i       (baseCol),
        .best_row_i       (baseRow),
        .second_sad_i     (baseSecond),
        .replace_best_o   (replaceBest),
        .replace_second_o (replaceSecond)
    );

    // An all-ones candidate can still win a distance tie, but it never counts as found.
    always_comb begin
        bestSad_d   = baseBest;
        secondSad_d = baseSecond;
        bestCol_d   = baseCol;
        bestRow_d   = baseRow;
        found_d     = baseFound;
        candCount_d = baseCount;
        if (accept) begin
            if (replaceBest) begin
                secondSad_d = baseBest;
                bestSad_d   = sad_in;
                bestCol_d   = col_in;
                bestRow_d   = row_in;
                found_d     = baseFound || (sad_in != SAD_ONES);
            end else if (replaceSecond) begin
                secondSad_d = sad_in;
            end
            if (baseCount != CNT_MAX) begin
                candCount_d = baseCount + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bestSad_q   <= SAD_ONES;
            secondSad_q <= SAD_ONES;
            bestCol_q   <= '0;
            bestRow_q   <= '0;
            found_q     <= 1'b0;
            candCount_q <= '0;
        end else begin
            bestSad_q   <= bestSad_d;
            secondSad_q <= secondSad_d;
            bestCol_q   <= bestCol_d;
            bestRow_q   <= bestRow_d;
            found_q     <= found_d;
            candCount_q <= candCount_d;
        end
    end

    always_comb begin
        best_sad   = bestSad_q;
        second_sad = secondSad_q;
        best_col   = bestCol_q;
        best_row   = bestRow_q;
        found      = found_q;
        cand_count = candCount_q;
        mv_x       = {1'b0, bestCol_q} - (COL_W + 1)'(CENTER_COL);
        mv_y       = {1'b0, bestRow_q} - (ROW_W + 1)'(CENTER_ROW);
    end

endmodule
